// File: rtl/button_pkg.sv
// Shared definitions for the button event decoder: FSM state encoding and
// default timing constants.
package button_pkg;

  // Decoder FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2,
    REPEAT  = 2'd3
  } btn_state_e;

  localparam int LONG_CYCLES_DEF   = 8;
  localparam int REPEAT_CYCLES_DEF = 4;

endpackage : button_pkg

// File: rtl/hold_timer.sv
// Hold-duration counter: synchronous clear, count enable, and a compare
// against a terminal-count value. Holds at the terminal count rather than
// running past it, so the count can never wrap.
module hold_timer #(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_tc_value,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;
  logic             w_tc;

  assign w_tc = (r_count == i_tc_value);
  assign o_tc = w_tc;

  // Count up while enabled; clear has priority; saturate at terminal count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule : hold_timer

// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced button level into press, release,
// long-press and auto-repeat pulses. All outputs are registered.
// Build option: define AUTO_REPEAT_EN to include the REPEAT state and
// repeat_pulse generation; otherwise repeat_pulse is tied low and the FSM
// parks in LONG until release.
//
// state   | meaning
// IDLE    | button released, waiting for a press edge
// PRESSED | held, counting toward the long-press threshold
// LONG    | long press reported, waiting for first repeat (or release)
// REPEAT  | auto-repeating every REPEAT_CYCLES while held
module button_event_decoder
  import button_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = 18
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_e       r_state;
  btn_state_e       w_state_nxt;
  logic             r_btn_q;
  logic             r_press, r_release, r_long, r_repeat, r_held;
  logic             w_press, w_release, w_long, w_repeat;
  logic             w_rise, w_fall;
  logic             w_clear, w_enable, w_tc;
  logic [CNT_W-1:0] w_tc_value;

  assign w_rise     = button_state & ~r_btn_q;
  assign w_fall     = ~button_state & r_btn_q;
  assign w_tc_value = (r_state == PRESSED) ? LONG_TC : REPEAT_TC;

  hold_timer #(
    .CNT_W(CNT_W)
  ) u_hold_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (w_clear),
    .i_enable  (w_enable),
    .i_tc_value(w_tc_value),
    .o_tc      (w_tc)
  );

  // State, input history and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_btn_q   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_btn_q   <= button_state;
      r_press   <= w_press;
      r_release <= w_release;
      r_long    <= w_long;
      r_repeat  <= w_repeat;
      r_held    <= (w_state_nxt != IDLE);
    end
  end

  // Next state, pulse requests and timer control; release beats any threshold
  always_comb begin
    w_state_nxt = r_state;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    w_clear     = 1'b0;
    w_enable    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_press     = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = PRESSED;
        end
      end
      PRESSED: begin
        if (w_fall) begin
          w_release   = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_tc) begin
          w_long      = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = LONG;
        end else begin
          w_enable    = 1'b1;
        end
      end
      LONG: begin
        if (w_fall) begin
          w_release   = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = IDLE;
        end
`ifdef AUTO_REPEAT_EN
        else if (w_tc) begin
          w_repeat    = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = REPEAT;
        end else begin
          w_enable    = 1'b1;
        end
`endif
      end
`ifdef AUTO_REPEAT_EN
      REPEAT: begin
        if (w_fall) begin
          w_release   = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_tc) begin
          w_repeat    = 1'b1;
          w_clear     = 1'b1;
        end else begin
          w_enable    = 1'b1;
        end
      end
`endif
      default: begin
        w_clear     = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign long_pulse    = r_long;
  assign held          = r_held;
`ifdef AUTO_REPEAT_EN
  assign repeat_pulse  = r_repeat;
`else
  assign repeat_pulse  = 1'b0;
`endif

endmodule : button_event_decoder

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder. Expected pulse events are
// pushed into a scoreboard queue before stimulus runs and popped as the
// DUT emits pulses. Edge 1 is the first rising clock edge after reset
// deasserts.
module tb_button_event_decoder;

  localparam int LONG_C = 8;
  localparam int REP_C  = 4;

  localparam int EV_PRESS   = 1;
  localparam int EV_RELEASE = 2;
  localparam int EV_LONG    = 3;
  localparam int EV_REPEAT  = 4;

  typedef struct {
    int code;
    int edge_n;
  } ev_t;

  logic clk;
  logic reset_n;
  logic button_state;
  logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;

  int   checks;
  int   errors;
  ev_t  exp_q[$];

  button_event_decoder #(
    .LONG_CYCLES  (LONG_C),
    .REPEAT_CYCLES(REP_C),
    .CNT_W        (18)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .button_state (button_state),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: events produced by one press held over edges a..b
  function automatic void push_expected(input int a, input int b);
    int t;
    exp_q.push_back('{EV_PRESS, a});
    t = a + LONG_C;
    if (t <= b) begin
      exp_q.push_back('{EV_LONG, t});
`ifdef AUTO_REPEAT_EN
      for (int r = t + REP_C; r <= b; r += REP_C) exp_q.push_back('{EV_REPEAT, r});
`endif
    end
    exp_q.push_back('{EV_RELEASE, b + 1});
  endfunction

  function automatic int code_of(input logic [3:0] p);
    if (p[3]) return EV_PRESS;
    if (p[2]) return EV_RELEASE;
    if (p[1]) return EV_LONG;
    if (p[0]) return EV_REPEAT;
    return 0;
  endfunction

  task automatic step(input logic b);
    button_state = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    button_state = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    reset_n      = 1'b0;
    button_state = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      obs = {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
      checks++;
      if (obs !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs iter=%0d got=%b want=00000", i, obs);
      end
      button_state = ~button_state;
      @(posedge clk);
      #1;
    end
  endtask

  // One or two press intervals (a2=0 disables the second), run for n edges
  task automatic test_pattern(input string name, input int a1, input int b1,
                              input int a2, input int b2, input int n);
    logic       b;
    logic [3:0] p;
    ev_t        ev;
    exp_q.delete();
    push_expected(a1, b1);
    if (a2 > 0) push_expected(a2, b2);
    do_reset();
    for (int e = 1; e <= n; e++) begin
      b = ((e >= a1) && (e <= b1)) || ((a2 > 0) && (e >= a2) && (e <= b2));
      step(b);
      p = {press_pulse, release_pulse, long_pulse, repeat_pulse};
      checks++;
      if ($countones(p) > 1) begin
        errors++;
        $display("FAIL %s onehot edge=%0d got=%b want=at most one", name, e, p);
      end
      checks++;
      if (held !== b) begin
        errors++;
        $display("FAIL %s held edge=%0d got=%b want=%b", name, e, held, b);
      end
      if (p != 4'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected pulse edge=%0d got=%0d want=none", name, e, code_of(p));
        end else begin
          ev = exp_q.pop_front();
          if (ev.code !== code_of(p) || ev.edge_n !== e) begin
            errors++;
            $display("FAIL %s event got=%0d@%0d want=%0d@%0d", name, code_of(p), e, ev.code, ev.edge_n);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing events got=%0d left want=0 (next %0d@%0d)", name,
               exp_q.size(), exp_q[0].code, exp_q[0].edge_n);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [3:0] p;
    logic [4:0] obs;
    ev_t        ev;
    exp_q.delete();
    exp_q.push_back('{EV_PRESS, 10});
    exp_q.push_back('{EV_LONG, 18});
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      step(e >= 10);
      p = {press_pulse, release_pulse, long_pulse, repeat_pulse};
      if (p != 4'b0) begin
        checks++;
        ev = exp_q.size() > 0 ? exp_q.pop_front() : '{0, 0};
        if (ev.code !== code_of(p) || ev.edge_n !== e) begin
          errors++;
          $display("FAIL midhold event got=%0d@%0d want=%0d@%0d", code_of(p), e, ev.code, ev.edge_n);
        end
      end
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL midhold held_before got=%b want=1", held);
    end
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      obs = {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
      checks++;
      if (obs !== 5'b0) begin
        errors++;
        $display("FAIL midhold in_reset iter=%0d got=%b want=00000", i, obs);
      end
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
    push_expected(1, 5);
    for (int e = 1; e <= 8; e++) begin
      step(e <= 5);
      p = {press_pulse, release_pulse, long_pulse, repeat_pulse};
      if (p != 4'b0) begin
        checks++;
        ev = exp_q.size() > 0 ? exp_q.pop_front() : '{0, 0};
        if (ev.code !== code_of(p) || ev.edge_n !== e) begin
          errors++;
          $display("FAIL midhold after_reset got=%0d@%0d want=%0d@%0d", code_of(p), e, ev.code, ev.edge_n);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midhold missing events got=%0d want=0", exp_q.size());
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset_n      = 1'b0;
    button_state = 1'b0;
    test_reset();
    test_pattern("short_press", 10, 14, 0, 0, 20);
    test_pattern("long_hold", 10, 40, 0, 0, 45);
    test_pattern("release_at_threshold", 10, 17, 0, 0, 22);
    test_pattern("glitch", 5, 5, 0, 0, 10);
    test_pattern("back_to_back", 3, 4, 6, 7, 12);
    test_pattern("long_hold_100", 10, 100, 0, 0, 105);
    test_pattern("repeat_boundary", 10, 22, 0, 0, 26);
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_button_event_decoder

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 The block SHALL have parameter LONG_CYCLES, default 8, meaning the number of held cycles from press_pulse to long_pulse (legal range 2..2^CNT_W-1).
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 4, meaning the period between repeat_pulse events (legal range 1..2^CNT_W-1).
REQ-003 The block SHALL have parameter CNT_W, default 18, meaning the hold-counter width.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 button_state  input  1  debounced, clk-synchronous button level (1 = pressed).
REQ-007 press_pulse  output  1  one-cycle pulse on a 0->1 transition of button_state.
REQ-008 release_pulse  output  1  one-cycle pulse on a 1->0 transition of button_state.
REQ-009 long_pulse  output  1  one-cycle pulse when the button has been held LONG_CYCLES cycles.
REQ-010 repeat_pulse  output  1  one-cycle periodic pulse while held past the long threshold.
REQ-011 held  output  1  level; 1 whenever the FSM is not IDLE.

Function
REQ-012 The block SHALL register button_state into btn_q and detect edges by comparing button_state against btn_q.
REQ-013 All outputs SHALL be registered, with no combinational path from button_state to any output.
REQ-014 The FSM SHALL have exactly these states: IDLE, PRESSED, LONG, REPEAT.
REQ-015 In IDLE, on the edge where button_state=1 and btn_q=0, the block SHALL assert press_pulse for one cycle, clear the counter, and go to PRESSED.
REQ-016 In PRESSED, the counter SHALL increment once per cycle; on the edge at which it equals LONG_CYCLES-1, the block SHALL assert long_pulse, clear the counter, and go to LONG.
REQ-017 long_pulse SHALL therefore rise exactly LONG_CYCLES cycles after press_pulse.
REQ-018 In LONG/REPEAT with auto-repeat enabled, the block SHALL assert repeat_pulse and clear the counter each time the counter reaches REPEAT_CYCLES-1, and enter REPEAT on the first repeat.
REQ-019 In any non-IDLE state, on the edge where button_state=0 and btn_q=1, the block SHALL assert release_pulse for one cycle, clear the counter, and go to IDLE.
REQ-020 When a release coincides with a counter threshold, release SHALL win: long_pulse and repeat_pulse SHALL stay 0 on that edge.
REQ-021 At most one of press_pulse, release_pulse, long_pulse, or repeat_pulse SHALL be high in any cycle.
REQ-022 The counter SHALL never wrap: in LONG with auto-repeat disabled it SHALL hold its value until release.
REQ-023 A one-cycle high glitch on button_state SHALL produce press_pulse, then release_pulse on the next cycle, and no long_pulse.
REQ-024 held SHALL equal (state != IDLE), registered.

Reset
REQ-025 While reset_n=0, the block SHALL be in IDLE with btn_q=0, counter=0, and all outputs 0, asynchronously.
REQ-026 Reset asserted mid-hold SHALL abort silently with no release_pulse.
REQ-027 After reset deasserts with button_state=1, the block SHALL emit press_pulse on the first active edge.

Configuration
REQ-028 Macro AUTO_REPEAT_EN defined: the block SHALL behave per REQ-018, with the REPEAT state and repeat_pulse logic present.
REQ-029 Macro AUTO_REPEAT_EN undefined: the REPEAT state and repeat logic SHALL be compiled out, repeat_pulse SHALL be tied to 0, and the FSM SHALL stay in LONG until release.

Structure
REQ-030 Shared package button_pkg SHALL hold the state enumeration (IDLE, PRESSED, LONG, REPEAT, 2-bit encoding) and the default LONG_CYCLES/REPEAT_CYCLES constants.
REQ-031 One sub-module, hold_timer (clear, enable, terminal-count compare, CNT_W wide), SHALL implement the counter, instanced once.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4, AUTO_REPEAT_EN defined unless stated)
REQ-032 Short press: button_state high edges 10..14 -> press_pulse at edge 10, release_pulse at edge 15, no long_pulse, held high for cycles 10..14.
REQ-033 Long hold with repeat: button_state high from edge 10 to 40 -> long_pulse at 18, repeat_pulse at 22, 26, 30, 34, 38, release_pulse at 41.
REQ-034 Release at threshold: button_state high edges 10..17, low at 18 -> release_pulse at 18, no long_pulse.
REQ-035 Glitch: button_state high for only edge 5 -> press_pulse at 5, release_pulse at 6.
REQ-036 Reset mid-hold: reset_n low at cycle 20 of a hold started at 10 -> all outputs 0 immediately, no release_pulse; button still high at reset release -> press_pulse on the first edge.
REQ-037 AUTO_REPEAT_EN undefined: button_state high 10..100 -> long_pulse at 18, repeat_pulse never asserted, held=1 until release_pulse at 101.
